// File: rtl/i2c_pkg.sv
// i2c_pkg: definitions shared by I2C target blocks.
//   i2c_state_t : byte-level protocol states of a target
//   GCALL_ADDR  : 7-bit general-call address
//   ACK_BIT     : SDA level that acknowledges a byte
//   NACK_BIT    : SDA level that refuses a byte
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8
  } i2c_state_t;

  localparam logic [6:0] GCALL_ADDR = 7'h00;
  localparam logic       ACK_BIT    = 1'b0;
  localparam logic       NACK_BIT   = 1'b1;

endpackage

// File: rtl/i2c_line_sync.sv
// i2c_line_sync: brings the raw SCL/SDA pins into the clk domain and flags
// bus events. Each event is a registered one-clk pulse.
//   clk, rst_n : system clock, asynchronous active-low reset
//   scl_i      : raw SCL pin
//   sda_i      : raw SDA pin
//   scl_rise   : SCL went low -> high
//   scl_fall   : SCL went high -> low
//   start      : SDA fell while SCL stayed high
//   stop       : SDA rose while SCL stayed high
//   sda_s      : synchronised SDA level, aligned with the event pulses
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop,
  output logic sda_s
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic                   r_scl_rise;
  logic                   r_scl_fall;
  logic                   r_start;
  logic                   r_stop;
  logic                   w_scl;
  logic                   w_sda;

  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];

  // Chains reset to the idle-bus level so leaving reset raises no event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
      r_scl_rise <= 1'b0;
      r_scl_fall <= 1'b0;
      r_start    <= 1'b0;
      r_stop     <= 1'b0;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], scl_i};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], sda_i};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
      r_scl_rise <= w_scl & ~r_scl_d;
      r_scl_fall <= ~w_scl & r_scl_d;
      // SCL must be high in both samples so an SCL edge is never a START/STOP.
      r_start    <= w_scl & r_scl_d & ~w_sda & r_sda_d;
      r_stop     <= w_scl & r_scl_d & w_sda & ~r_sda_d;
    end
  end

  assign scl_rise = r_scl_rise;
  assign scl_fall = r_scl_fall;
  assign start    = r_start;
  assign stop     = r_stop;
  assign sda_s    = r_sda_d;

endmodule

// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: system-clocked I2C target with a byte register file,
// auto-incrementing pointer and repeated-START support.
//   clk, rst_n          : system clock, asynchronous active-low reset
//   scl_i, sda_i        : raw bus pins (SCL is never driven)
//   sda_oe              : 1 pulls SDA low
//   busy                : addressed, from the address ACK until STOP or a
//                         START with a non-matching address
//   wr_strobe           : one-clk pulse per committed I2C byte
//   wr_addr, wr_data    : index/value of the last committed byte (held)
//   host_we/addr/wdata  : host write port
//   host_rdata          : regs[host_addr], combinational
//   dbg_state           : current protocol state (i2c_state_t encoding)
// Build option I2C_GCALL_EN: ACK general-call writes (7'h00 + W).
//
// Bus handshake: SDA is sampled on the SCL rise event and sda_oe only
// changes on the SCL fall event; every byte transition is taken at the
// fall event that ends its 8th bit or its ACK bit.
module i2c_slave_regfile
  import i2c_pkg::*;
#(
  parameter logic [6:0] ADDRESS     = 7'h50,
  parameter int         NUM_REGS    = 16,
  parameter int         SYNC_STAGES = 2,
  localparam int        PTR_W       = $clog2(NUM_REGS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  output logic             busy,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_addr,
  output logic [7:0]       wr_data,
  input  logic             host_we,
  input  logic [PTR_W-1:0] host_addr,
  input  logic [7:0]       host_wdata,
  output logic [7:0]       host_rdata,
  output logic [3:0]       dbg_state
);

  logic w_scl_rise, w_scl_fall, w_start, w_stop, w_sda_s;

  i2c_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_line_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl_i    (scl_i),
    .sda_i    (sda_i),
    .scl_rise (w_scl_rise),
    .scl_fall (w_scl_fall),
    .start    (w_start),
    .stop     (w_stop),
    .sda_s    (w_sda_s)
  );

  i2c_state_t       r_state, w_state_nxt;
  logic [2:0]       r_cnt, w_cnt_nxt;
  logic             r_done, w_done_nxt;       // 8th bit of the byte seen
  logic [7:0]       r_shift, w_shift_nxt;
  logic [PTR_W-1:0] r_ptr, w_ptr_nxt;
  logic             r_rw, w_rw_nxt;
  logic             r_host_ack, w_host_ack_nxt;
  logic             r_sda_oe, w_sda_oe_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_wr_strobe;
  logic [PTR_W-1:0] r_wr_addr;
  logic [7:0]       r_wr_data;
  logic             w_commit;
  logic [7:0]       r_regs [NUM_REGS];
  logic [PTR_W-1:0] w_ptr_inc;
  logic             w_gcall_hit, w_addr_hit, w_ptr_ok;
  logic [7:0]       w_rd_cur, w_rd_nxt;

  assign w_ptr_inc = (r_ptr == PTR_W'(NUM_REGS - 1)) ? '0 : r_ptr + 1'b1;
  assign w_ptr_ok  = ({1'b0, r_shift} < 9'(NUM_REGS));
  assign w_rd_cur  = r_regs[r_ptr];
  assign w_rd_nxt  = r_regs[w_ptr_inc];

`ifdef I2C_GCALL_EN
  assign w_gcall_hit = (r_shift[7:1] == GCALL_ADDR) && !r_shift[0];
`else
  assign w_gcall_hit = 1'b0;
`endif
  assign w_addr_hit = (r_shift[7:1] == ADDRESS) || w_gcall_hit;

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_done_nxt     = r_done;
    w_shift_nxt    = r_shift;
    w_ptr_nxt      = r_ptr;
    w_rw_nxt       = r_rw;
    w_host_ack_nxt = r_host_ack;
    w_sda_oe_nxt   = r_sda_oe;
    w_busy_nxt     = r_busy;
    w_commit       = 1'b0;
    if (w_stop) begin
      w_state_nxt  = ST_IDLE;
      w_sda_oe_nxt = 1'b0;
      w_busy_nxt   = 1'b0;
      w_done_nxt   = 1'b0;
    end else if (w_start) begin
      w_state_nxt  = ST_ADDR;
      w_cnt_nxt    = 3'd7;
      w_done_nxt   = 1'b0;
      w_sda_oe_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (w_scl_rise) begin
            w_shift_nxt = {r_shift[6:0], w_sda_s};
            w_cnt_nxt   = r_cnt - 3'd1;
            w_done_nxt  = (r_cnt == 3'd0);
          end else if (w_scl_fall && r_done) begin
            w_done_nxt = 1'b0;
            if (r_state == ST_ADDR) begin
              w_rw_nxt = r_shift[0];
              if (w_addr_hit) begin
                w_state_nxt  = ST_ADDR_ACK;
                w_sda_oe_nxt = ACK_BIT ^ 1'b1;
                w_busy_nxt   = 1'b1;
              end else begin
                w_state_nxt = ST_IDLE;
                w_busy_nxt  = 1'b0;
              end
            end else if (r_state == ST_PTR) begin
              if (w_ptr_ok) begin
                w_state_nxt  = ST_PTR_ACK;
                w_sda_oe_nxt = 1'b1;
                w_ptr_nxt    = r_shift[PTR_W-1:0];
              end else begin
                w_state_nxt = ST_IDLE;
              end
            end else begin
              w_state_nxt  = ST_WDATA_ACK;
              w_sda_oe_nxt = 1'b1;
            end
          end
        end
        ST_ADDR_ACK: begin
          if (w_scl_fall) begin
            w_cnt_nxt = 3'd7;
            if (!r_rw) begin
              w_state_nxt  = ST_PTR;
              w_sda_oe_nxt = 1'b0;
            end else begin
              w_state_nxt  = ST_RDATA;
              w_shift_nxt  = w_rd_cur;
              w_sda_oe_nxt = ~w_rd_cur[7];
            end
          end
        end
        ST_PTR_ACK: begin
          if (w_scl_fall) begin
            w_state_nxt  = ST_WDATA;
            w_sda_oe_nxt = 1'b0;
            w_cnt_nxt    = 3'd7;
          end
        end
        ST_WDATA_ACK: begin
          if (w_scl_fall) begin
            w_commit     = 1'b1;
            w_ptr_nxt    = w_ptr_inc;
            w_state_nxt  = ST_WDATA;
            w_sda_oe_nxt = 1'b0;
            w_cnt_nxt    = 3'd7;
          end
        end
        ST_RDATA: begin
          if (w_scl_rise) begin
            w_cnt_nxt  = r_cnt - 3'd1;
            w_done_nxt = (r_cnt == 3'd0);
          end else if (w_scl_fall) begin
            if (r_done) begin
              w_done_nxt   = 1'b0;
              w_state_nxt  = ST_RDATA_ACK;
              w_sda_oe_nxt = 1'b0;
            end else begin
              w_shift_nxt  = {r_shift[6:0], 1'b0};
              w_sda_oe_nxt = ~r_shift[6];
            end
          end
        end
        ST_RDATA_ACK: begin
          if (w_scl_rise) begin
            w_host_ack_nxt = w_sda_s;
          end else if (w_scl_fall) begin
            if (r_host_ack == ACK_BIT) begin
              w_ptr_nxt    = w_ptr_inc;
              w_shift_nxt  = w_rd_nxt;
              w_sda_oe_nxt = ~w_rd_nxt[7];
              w_state_nxt  = ST_RDATA;
              w_cnt_nxt    = 3'd7;
            end else begin
              w_state_nxt = ST_IDLE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= 3'd7;
      r_done      <= 1'b0;
      r_shift     <= '0;
      r_ptr       <= '0;
      r_rw        <= 1'b0;
      r_host_ack  <= NACK_BIT;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_done      <= w_done_nxt;
      r_shift     <= w_shift_nxt;
      r_ptr       <= w_ptr_nxt;
      r_rw        <= w_rw_nxt;
      r_host_ack  <= w_host_ack_nxt;
      r_sda_oe    <= w_sda_oe_nxt;
      r_busy      <= w_busy_nxt;
      r_wr_strobe <= w_commit;
      if (w_commit) begin
        r_wr_addr <= r_ptr;
        r_wr_data <= r_shift;
      end
    end
  end

  // The I2C commit is the later assignment, so it wins a same-index collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      if (host_we && (int'(host_addr) < NUM_REGS)) r_regs[host_addr] <= host_wdata;
      if (w_commit) r_regs[r_ptr] <= r_shift;
    end
  end

  assign host_rdata = (int'(host_addr) < NUM_REGS) ? r_regs[host_addr] : 8'h00;
  assign sda_oe     = r_sda_oe;
  assign busy       = r_busy;
  assign wr_strobe  = r_wr_strobe;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign dbg_state  = r_state;

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Bench for i2c_slave_regfile: bit-level I2C controller driver tasks, a
// transaction-level register model and a commit scoreboard.
module tb_i2c_slave_regfile;

  localparam int NREG = 16;
`ifdef I2C_GCALL_EN
  localparam logic GC_EXP_ACK = 1'b0;
`else
  localparam logic GC_EXP_ACK = 1'b1;
`endif

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       scl_i = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_i;
  logic       sda_oe, busy, wr_strobe;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  logic       host_we = 1'b0;
  logic [3:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic [7:0] host_rdata;
  logic [3:0] dbg_state;

  // open-drain bus: either side may pull low
  assign sda_i = m_sda & ~sda_oe;

  i2c_slave_regfile #(.ADDRESS(7'h50), .NUM_REGS(NREG), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .scl_i      (scl_i),
    .sda_i      (sda_i),
    .sda_oe     (sda_oe),
    .busy       (busy),
    .wr_strobe  (wr_strobe),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .host_we    (host_we),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .dbg_state  (dbg_state)
  );

  int          total = 0;
  int          bad = 0;
  logic [7:0]  model_regs [NREG];
  logic [11:0] exp_q [$];
  logic [7:0]  wbuf [4];
  bit          oe_seen;
  logic [11:0] mon_e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every commit strobe must match the next expected (index,data)
  always @(negedge clk) begin
    if (sda_oe === 1'b1) oe_seen = 1'b1;
    if (rst_n && wr_strobe === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_commit", 32'(wr_strobe), 32'(0));
      end else begin
        mon_e = exp_q.pop_front();
        chk("commit", 32'({wr_addr, wr_data}), 32'(mon_e));
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    m_sda = b; tick(5);
    scl_i = 1'b1; tick(10);
    scl_i = 1'b0; tick(5);
  endtask

  task automatic recv_bit(output logic b);
    m_sda = 1'b1; tick(5);
    scl_i = 1'b1; tick(5);
    b = sda_i; tick(5);
    scl_i = 1'b0; tick(5);
  endtask

  task automatic i2c_start();
    m_sda = 1'b1; tick(5);
    scl_i = 1'b1; tick(10);
    m_sda = 1'b0; tick(10);
    scl_i = 1'b0; tick(5);
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; tick(5);
    scl_i = 1'b1; tick(10);
    m_sda = 1'b1; tick(10);
  endtask

  // collide: host writes cv to index ca in the clk the target commits,
  // which is SYNC_STAGES+2 clk after the ACK's SCL falling pin edge
  task automatic write_byte(input logic [7:0] d, input bit collide, input logic [3:0] ca,
                            input logic [7:0] cv, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    m_sda = 1'b1; tick(5);
    scl_i = 1'b1; tick(5);
    ack = sda_i; tick(5);
    scl_i = 1'b0;
    if (collide) begin
      tick(3);
      host_we = 1'b1; host_addr = ca; host_wdata = cv;
      tick(1);
      host_we = 1'b0;
      chk("collide_same_clk", 32'(wr_strobe), 32'(1));
      tick(1);
    end else begin
      tick(5);
    end
  endtask

  task automatic read_byte(output logic [7:0] d, input logic ack_bit);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(ack_bit);
  endtask

  task automatic host_write(input int a, input logic [7:0] d);
    host_we = 1'b1; host_addr = 4'(a); host_wdata = d;
    tick(1);
    host_we = 1'b0;
    model_regs[a] = d;
  endtask

  task automatic chk_host(input int a);
    host_addr = 4'(a);
    #1;
    chk("host_rdata", 32'(host_rdata), 32'(model_regs[a]));
  endtask

  task automatic do_write(input logic [7:0] p, input int n, input bit collide);
    logic a;
    int   mp;
    i2c_start();
    write_byte(8'hA0, 1'b0, 4'd0, 8'd0, a);
    chk("w_addr_ack", 32'(a), 32'(0));
    chk("busy_after_ack", 32'(busy), 32'(1));
    write_byte(p, 1'b0, 4'd0, 8'd0, a);
    chk("w_ptr_ack", 32'(a), (int'(p) < NREG) ? 32'(0) : 32'(1));
    if (int'(p) < NREG) begin
      mp = int'(p);
      for (int i = 0; i < n; i++) begin
        exp_q.push_back({4'(mp), wbuf[i]});
        model_regs[mp] = wbuf[i];
        write_byte(wbuf[i], collide && (i == 0), 4'(mp), ~wbuf[i], a);
        chk("w_data_ack", 32'(a), 32'(0));
        mp = (mp + 1) % NREG;
      end
    end else begin
      // target has gone idle: a further byte must be refused and not stored
      write_byte(8'h77, 1'b0, 4'd0, 8'd0, a);
      chk("w_after_nack", 32'(a), 32'(1));
    end
    i2c_stop();
    tick(3);
    chk("busy_after_stop", 32'(busy), 32'(0));
  endtask

  task automatic do_read(input int p, input int n);
    logic       a;
    logic [7:0] d;
    int         mp;
    i2c_start();
    write_byte(8'hA0, 1'b0, 4'd0, 8'd0, a);
    chk("r_addr_w_ack", 32'(a), 32'(0));
    write_byte(8'(p), 1'b0, 4'd0, 8'd0, a);
    chk("r_ptr_ack", 32'(a), 32'(0));
    i2c_start();
    write_byte(8'hA1, 1'b0, 4'd0, 8'd0, a);
    chk("r_addr_r_ack", 32'(a), 32'(0));
    mp = p;
    for (int i = 0; i < n; i++) begin
      read_byte(d, (i == n - 1) ? 1'b1 : 1'b0);
      chk("rd_data", 32'(d), 32'(model_regs[mp]));
      mp = (mp + 1) % NREG;
    end
    chk("busy_before_stop", 32'(busy), 32'(1));
    i2c_stop();
    tick(3);
    chk("busy_after_rd_stop", 32'(busy), 32'(0));
  endtask

  initial begin
    logic a;
    int   p, n, waited;

    for (int i = 0; i < NREG; i++) model_regs[i] = 8'h00;

    // reset state
    tick(3);
    chk("rst_sda_oe", 32'(sda_oe), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_wr_strobe", 32'(wr_strobe), 32'(0));
    chk("rst_wr_addr", 32'(wr_addr), 32'(0));
    chk("rst_wr_data", 32'(wr_data), 32'(0));
    rst_n = 1'b1;
    tick(2);
    for (int i = 0; i < NREG; i++) chk_host(i);

    // basic multi-byte write
    wbuf[0] = 8'hA5; wbuf[1] = 8'h5A;
    do_write(8'h03, 2, 1'b0);
    chk_host(3);
    chk_host(4);
    chk("wr_addr_hold", 32'(wr_addr), 32'(4));
    chk("wr_data_hold", 32'(wr_data), 32'(8'h5A));

    // read two bytes after repeated START
    host_write(2, 8'($urandom_range(0, 255)));
    do_read(2, 2);

    // pointer wrap at the last register
    wbuf[0] = 8'($urandom_range(0, 255)); wbuf[1] = 8'($urandom_range(0, 255));
    do_write(8'h0F, 2, 1'b0);
    chk_host(15);
    chk_host(0);

    // other address: never drives SDA
    oe_seen = 1'b0;
    i2c_start();
    write_byte(8'hA2, 1'b0, 4'd0, 8'd0, a);
    chk("mis_addr_nack", 32'(a), 32'(1));
    write_byte(8'($urandom_range(0, 255)), 1'b0, 4'd0, 8'd0, a);
    i2c_stop();
    tick(3);
    chk("mis_no_oe", 32'(oe_seen), 32'(0));
    chk("mis_busy", 32'(busy), 32'(0));

    // pointer out of range
    do_write(8'h20, 0, 1'b0);

    // host and I2C write the same index in the same clk
    wbuf[0] = 8'($urandom_range(0, 255));
    do_write(8'h05, 1, 1'b1);
    chk_host(5);

    // random write bursts read back through I2C
    for (int k = 0; k < 4; k++) begin
      p = $urandom_range(0, NREG - 1);
      n = $urandom_range(1, 3);
      for (int i = 0; i < 4; i++) wbuf[i] = 8'($urandom_range(0, 255));
      do_write(8'(p), n, 1'b0);
      do_read(p, n);
    end

    // reset while the target drives a read bit low
    host_write(0, 8'h00);
    i2c_start();
    write_byte(8'hA0, 1'b0, 4'd0, 8'd0, a);
    write_byte(8'h00, 1'b0, 4'd0, 8'd0, a);
    i2c_start();
    write_byte(8'hA1, 1'b0, 4'd0, 8'd0, a);
    waited = 0;
    while (sda_oe !== 1'b1 && waited < 100) begin
      tick(1);
      waited++;
    end
    chk("rd_oe_driven", 32'(sda_oe), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("rst_oe_async", 32'(sda_oe), 32'(0));
    scl_i = 1'b1; m_sda = 1'b1;
    tick(2);
    chk("rst_busy_mid", 32'(busy), 32'(0));
    for (int i = 0; i < NREG; i++) model_regs[i] = 8'h00;
    rst_n = 1'b1;
    tick(2);
    chk_host(5);
    chk_host(3);

    // general call address
    i2c_start();
    write_byte(8'h00, 1'b0, 4'd0, 8'd0, a);
    chk("gcall_ack", 32'(a), 32'(GC_EXP_ACK));
    i2c_stop();
    tick(10);

    chk("pending_commits", 32'(exp_q.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
